// File: rtl/sram_pkg.sv
// Shared types and address decode for the banked SRAM array.
// Holds the FSM states, the default error data word and the bank/row decoder.
package sram_pkg;

  typedef enum logic {
    ST_SCRUB,
    ST_READY
  } state_e;

  localparam logic [31:0] ERR_RDATA_DEF = 32'hDEAD_BEEF;

  typedef struct packed {
    logic        legal;
    logic [3:0]  bank;
    logic [15:0] row;
  } dec_t;

  // Wide arithmetic keeps END from wrapping near the top of the map.
  function automatic dec_t sram_decode(
    input logic [31:0] addr,
    input logic [31:0] base,
    input int unsigned banks,
    input int unsigned words
  );
    dec_t        d;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] e;
    logic [63:0] off;
    a       = 64'(addr);
    b       = 64'(base);
    e       = b + 64'(banks) * 64'(words) * 64'd4;
    off     = (a - b) >> 2;
    d.legal = (a >= b) && (a < e);
    d.bank  = 4'(off / 64'(words));
    d.row   = 16'(off % 64'(words));
    return d;
  endfunction

endpackage

// File: rtl/sram_bank_array_if.sv
// OBI data and instruction ports of the SRAM array.
// master = requester side, slave = memory side.
interface sram_bank_array_if;

  logic        d_req_i;
  logic        d_gnt_o;
  logic [31:0] d_addr_i;
  logic        d_we_i;
  logic [3:0]  d_be_i;
  logic [31:0] d_wdata_i;
  logic        d_rvalid_o;
  logic [31:0] d_rdata_o;
  logic        d_err_o;

  logic        i_req_i;
  logic        i_gnt_o;
  logic [31:0] i_addr_i;
  logic        i_we_i;
  logic        i_rvalid_o;
  logic [31:0] i_rdata_o;
  logic        i_err_o;

  modport master (
    output d_req_i, d_addr_i, d_we_i, d_be_i, d_wdata_i,
    input  d_gnt_o, d_rvalid_o, d_rdata_o, d_err_o,
    output i_req_i, i_addr_i, i_we_i,
    input  i_gnt_o, i_rvalid_o, i_rdata_o, i_err_o
  );

  modport slave (
    input  d_req_i, d_addr_i, d_we_i, d_be_i, d_wdata_i,
    output d_gnt_o, d_rvalid_o, d_rdata_o, d_err_o,
    input  i_req_i, i_addr_i, i_we_i,
    output i_gnt_o, i_rvalid_o, i_rdata_o, i_err_o
  );

endinterface

// File: rtl/sram_bank.sv
// One 1rw1r 32-bit macro (behavioural equivalent of the sky130 OpenRAM
// 32x512 part) with the port-0 mux between scrub and data traffic.
module sram_bank #(
  parameter int unsigned WORDS = 512,
  parameter int          RW    = 9
) (
  input  logic          clk_i,
  input  logic          scrub_i,
  input  logic [RW-1:0] scrub_row_i,
  input  logic          d_cs_i,
  input  logic          d_we_i,
  input  logic [3:0]    d_be_i,
  input  logic [RW-1:0] d_row_i,
  input  logic [31:0]   d_wdata_i,
  output logic [31:0]   d_rdata_o,
  input  logic          i_cs_i,
  input  logic [RW-1:0] i_row_i,
  output logic [31:0]   i_rdata_o
);

  logic [31:0]   mem [WORDS];
  logic          cs0;
  logic          we0;
  logic [3:0]    mask0;
  logic [RW-1:0] row0;
  logic [31:0]   din0;

  // Scrub owns port 0 outright; grants are held off while it runs.
  always_comb begin
    cs0   = d_cs_i;
    we0   = d_we_i;
    mask0 = d_be_i;
    row0  = d_row_i;
    din0  = d_wdata_i;
    if (scrub_i) begin
      cs0   = 1'b1;
      we0   = 1'b1;
      mask0 = 4'hF;
      row0  = scrub_row_i;
      din0  = '0;
    end
  end

  // Byte-masked write on port 0, registered reads on both ports.
  always_ff @(posedge clk_i) begin
    if (cs0 && we0) begin
      for (int i = 0; i < 4; i++) begin
        if (mask0[i]) mem[row0][8*i+:8] <= din0[8*i+:8];
      end
    end
    if (cs0 && !we0) d_rdata_o <= mem[row0];
    if (i_cs_i) i_rdata_o <= mem[i_row_i];
  end

endmodule

// File: rtl/sram_bank_array.sv
// NUM_BANKS SRAM macros behind OBI data and instruction ports, with
// post-reset zero scrub, bounds checking and sticky error capture.
module sram_bank_array
  import sram_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
  parameter int unsigned NUM_BANKS  = 12,
  parameter int unsigned BANK_WORDS = 512,
  parameter bit          SCRUB_EN   = 1'b1,
  parameter logic [31:0] ERR_RDATA  = ERR_RDATA_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  sram_bank_array_if.slave bus,
  output logic             scrub_busy_o,
  output logic             illegal_memory_o,
  output logic             err_valid_o,
  output logic [31:0]      err_addr_o,
  input  logic             err_clr_i
);

  localparam int RW = $clog2(BANK_WORDS);

  state_e        state_q;
  state_e        state_d;
  logic [RW-1:0] row_q;
  logic [RW-1:0] row_d;
  logic          ready;
  logic          scrub;

  dec_t          d_dec;
  dec_t          i_dec;
  logic          d_err;
  logic          i_err;
  logic          d_gnt;
  logic          i_gnt;
  logic          collide;
  logic          d_bad;
  logic          i_bad;

  logic [31:0]   d_rd [NUM_BANKS];
  logic [31:0]   i_rd [NUM_BANKS];
  logic [31:0]   d_mem;
  logic [31:0]   i_mem;

  logic          d_rv_q;
  logic          d_err_q;
  logic          d_we_q;
  logic [3:0]    d_bank_q;
  logic          i_rv_q;
  logic          i_err_q;
  logic [3:0]    i_bank_q;

  // FSM state and scrub row counter.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= SCRUB_EN ? ST_SCRUB : ST_READY;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
    end
  end

  // Walk every row once, then serve traffic.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    unique case (state_q)
      ST_SCRUB: begin
        if (row_q == RW'(BANK_WORDS - 1)) begin
          state_d = ST_READY;
          row_d   = '0;
        end else begin
          row_d = row_q + 1'b1;
        end
      end
      ST_READY: ;
    endcase
  end

  // FSM outputs; reset also blocks grants and scrub writes.
  always_comb begin
    scrub_busy_o = (state_q == ST_SCRUB);
    scrub        = scrub_busy_o && !rst_i;
    ready        = (state_q == ST_READY) && !rst_i;
  end

  assign d_dec = sram_decode(bus.d_addr_i, BASE_ADDR,
                             NUM_BANKS, BANK_WORDS);
  assign i_dec = sram_decode(bus.i_addr_i, BASE_ADDR,
                             NUM_BANKS, BANK_WORDS);

  assign d_err   = !d_dec.legal;
  assign i_err   = !i_dec.legal || bus.i_we_i;
  assign d_gnt   = bus.d_req_i && ready;
  assign collide = d_gnt && bus.d_we_i && !d_err && !i_err
                && (d_dec.bank == i_dec.bank)
                && (d_dec.row == i_dec.row);
  assign i_gnt   = bus.i_req_i && ready && !collide;
  assign d_bad   = d_gnt && d_err;
  assign i_bad   = i_gnt && i_err;

  assign bus.d_gnt_o = d_gnt;
  assign bus.i_gnt_o = i_gnt;

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    sram_bank #(
      .WORDS(BANK_WORDS),
      .RW   (RW)
    ) u_bank (
      .clk_i      (clk_i),
      .scrub_i    (scrub),
      .scrub_row_i(row_q),
      .d_cs_i     (d_gnt && !d_err && d_dec.bank == 4'(b)),
      .d_we_i     (bus.d_we_i),
      .d_be_i     (bus.d_be_i),
      .d_row_i    (RW'(d_dec.row)),
      .d_wdata_i  (bus.d_wdata_i),
      .d_rdata_o  (d_rd[b]),
      .i_cs_i     (i_gnt && !i_err && i_dec.bank == 4'(b)),
      .i_row_i    (RW'(i_dec.row)),
      .i_rdata_o  (i_rd[b])
    );
  end

  // Response pipeline: one response per grant, one cycle later.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      d_rv_q           <= 1'b0;
      d_err_q          <= 1'b0;
      d_we_q           <= 1'b0;
      d_bank_q         <= '0;
      i_rv_q           <= 1'b0;
      i_err_q          <= 1'b0;
      i_bank_q         <= '0;
      illegal_memory_o <= 1'b0;
    end else begin
      d_rv_q           <= d_gnt;
      d_err_q          <= d_bad;
      d_we_q           <= d_gnt && bus.d_we_i;
      d_bank_q         <= d_dec.bank;
      i_rv_q           <= i_gnt;
      i_err_q          <= i_bad;
      i_bank_q         <= i_dec.bank;
      illegal_memory_o <= d_bad || i_bad;
    end
  end

  // Read mux keyed by the bank captured at grant time.
  always_comb begin
    d_mem = '0;
    i_mem = '0;
    for (int b = 0; b < int'(NUM_BANKS); b++) begin
      if (d_bank_q == 4'(b)) d_mem = d_rd[b];
      if (i_bank_q == 4'(b)) i_mem = i_rd[b];
    end
  end

  assign bus.d_rvalid_o = d_rv_q;
  assign bus.d_err_o    = d_err_q;
  assign bus.d_rdata_o  = !d_rv_q ? '0
                        : d_err_q ? ERR_RDATA
                        : d_we_q  ? '0 : d_mem;
  assign bus.i_rvalid_o = i_rv_q;
  assign bus.i_err_o    = i_err_q;
  assign bus.i_rdata_o  = !i_rv_q ? '0
                        : i_err_q ? ERR_RDATA : i_mem;

  // Sticky first-error capture; a new error beats a same-cycle clear.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_valid_o <= 1'b0;
      err_addr_o  <= '0;
    end else if ((d_bad || i_bad) && (!err_valid_o || err_clr_i)) begin
      err_valid_o <= 1'b1;
      err_addr_o  <= d_bad ? bus.d_addr_i : bus.i_addr_i;
    end else if (err_clr_i) begin
      err_valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sram_bank_array.sv
// Scoreboard bench for sram_bank_array: 12-bank main instance
// plus a 3-bank instance for scrub restart and short-range bounds.
module tb_sram_bank_array;

  logic        clk = 1'b0;
  logic        rst;
  logic        rst3;
  logic        err_clr;
  logic        err_clr3;
  logic        busy, ill, ev;
  logic [31:0] ea;
  logic        busy3, ill3, ev3;
  logic [31:0] ea3;

  always #5 clk = ~clk;

  sram_bank_array_if bus ();
  sram_bank_array_if bus3 ();

  sram_bank_array dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .bus             (bus),
    .scrub_busy_o    (busy),
    .illegal_memory_o(ill),
    .err_valid_o     (ev),
    .err_addr_o      (ea),
    .err_clr_i       (err_clr)
  );

  sram_bank_array #(.NUM_BANKS(3)) dut3 (
    .clk_i           (clk),
    .rst_i           (rst3),
    .bus             (bus3),
    .scrub_busy_o    (busy3),
    .illegal_memory_o(ill3),
    .err_valid_o     (ev3),
    .err_addr_o      (ea3),
    .err_clr_i       (err_clr3)
  );

  typedef struct {
    logic [31:0] rd;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t dq[$];
  exp_t iq[$];
  exp_t de, ie;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   cnt;
  logic gseen;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.d_rvalid_o) begin
      if (dq.size() == 0) chk("d_spurious", 32'd1, 32'd0);
      else begin
        de = dq.pop_front();
        chk("d_rdata", bus.d_rdata_o, de.rd);
        chk("d_err", 32'(bus.d_err_o), 32'(de.err));
        chk("d_lat", 32'(cyc - de.cyc), 32'd1);
      end
    end
    if (bus.i_rvalid_o) begin
      if (iq.size() == 0) chk("i_spurious", 32'd1, 32'd0);
      else begin
        ie = iq.pop_front();
        chk("i_rdata", bus.i_rdata_o, ie.rd);
        chk("i_err", 32'(bus.i_err_o), 32'(ie.err));
        chk("i_lat", 32'(cyc - ie.cyc), 32'd1);
      end
    end
  end

  task automatic d_xfer(input logic [31:0] a, input logic we,
                        input logic [3:0] be, input logic [31:0] wd,
                        input logic [31:0] rd, input logic err);
    int   n;
    exp_t e;
    n = 0;
    bus.d_req_i   = 1'b1;
    bus.d_addr_i  = a;
    bus.d_we_i    = we;
    bus.d_be_i    = be;
    bus.d_wdata_i = wd;
    @(negedge clk);
    while (!bus.d_gnt_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (bus.d_gnt_o) begin
      e.rd = rd; e.err = err; e.cyc = cyc;
      dq.push_back(e);
    end else chk("d_gnt_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1 bus.d_req_i = 1'b0;
  endtask

  task automatic i_xfer(input logic [31:0] a, input logic we,
                        input logic [31:0] rd, input logic err);
    int   n;
    exp_t e;
    n = 0;
    bus.i_req_i  = 1'b1;
    bus.i_addr_i = a;
    bus.i_we_i   = we;
    @(negedge clk);
    while (!bus.i_gnt_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (bus.i_gnt_o) begin
      e.rd = rd; e.err = err; e.cyc = cyc;
      iq.push_back(e);
    end else chk("i_gnt_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1 bus.i_req_i = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    exp_t e;
    rst = 1'b1; rst3 = 1'b1; err_clr = 1'b0; err_clr3 = 1'b0;
    bus.d_req_i = 1'b1; bus.d_addr_i = 32'h8000_0000;
    bus.d_we_i = 1'b0; bus.d_be_i = 4'hF; bus.d_wdata_i = '0;
    bus.i_req_i = 1'b1; bus.i_addr_i = 32'h8000_0004; bus.i_we_i = 1'b0;
    bus3.d_req_i = 1'b0; bus3.d_addr_i = '0; bus3.d_we_i = 1'b0;
    bus3.d_be_i = 4'hF; bus3.d_wdata_i = '0;
    bus3.i_req_i = 1'b0; bus3.i_addr_i = '0; bus3.i_we_i = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_dgnt", 32'(bus.d_gnt_o), 32'd0);
    chk("rst_ignt", 32'(bus.i_gnt_o), 32'd0);
    chk("rst_rvalid", 32'(bus.d_rvalid_o), 32'd0);
    chk("rst_rdata", bus.d_rdata_o, 32'd0);
    chk("rst_ill", 32'(ill), 32'd0);
    chk("rst_ev", 32'(ev), 32'd0);
    chk("rst_ea", ea, 32'd0);

    @(posedge clk);
    #1 rst = 1'b0;
    cnt = 0; gseen = 1'b0;
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk);
      if (!busy) break;
      cnt++;
      if (bus.d_gnt_o || bus.i_gnt_o) gseen = 1'b1;
    end
    bus.d_req_i = 1'b0;
    bus.i_req_i = 1'b0;
    chk("scrub_len", 32'(cnt), 32'd512);
    chk("scrub_gnt", 32'(gseen), 32'd0);
    @(posedge clk);
    #1;

    i_xfer(32'h8000_1234, 1'b0, 32'h0, 1'b0);
    d_xfer(32'h8000_5FFC, 1'b1, 4'hF, 32'hCAFE_F00D, 32'h0, 1'b0);
    chk("ill_low", 32'(ill), 32'd0);
    i_xfer(32'h8000_5FFC, 1'b0, 32'hCAFE_F00D, 1'b0);

    d_xfer(32'h8000_0800, 1'b1, 4'hF, 32'hAAAA_BBBB, 32'h0, 1'b0);
    d_xfer(32'h8000_0800, 1'b1, 4'b0011, 32'h1111_2222, 32'h0, 1'b0);
    d_xfer(32'h8000_1000, 1'b1, 4'hF, 32'h0BAD_F00D, 32'h0, 1'b0);
    d_xfer(32'h8000_0800, 1'b0, 4'hF, 32'h0, 32'hAAAA_2222, 1'b0);
    d_xfer(32'h8000_1000, 1'b0, 4'hF, 32'h0, 32'h0BAD_F00D, 1'b0);

    d_xfer(32'h8000_6000, 1'b0, 4'hF, 32'h0, 32'hDEAD_BEEF, 1'b1);
    chk("ill_pulse", 32'(ill), 32'd1);
    chk("ev_set", 32'(ev), 32'd1);
    chk("ea_first", ea, 32'h8000_6000);
    i_xfer(32'h8000_0000, 1'b1, 32'hDEAD_BEEF, 1'b1);
    chk("ea_hold", ea, 32'h8000_6000);
    fork
      begin
        err_clr = 1'b1;
        @(posedge clk);
        #1 err_clr = 1'b0;
      end
      d_xfer(32'h7FFF_FFFC, 1'b0, 4'hF, 32'h0, 32'hDEAD_BEEF, 1'b1);
    join
    chk("ev_clr_new", 32'(ev), 32'd1);
    chk("ea_clr_new", ea, 32'h7FFF_FFFC);
    err_clr = 1'b1;
    @(posedge clk);
    #1 err_clr = 1'b0;
    chk("ev_clr", 32'(ev), 32'd0);
    fork
      d_xfer(32'h9000_0000, 1'b0, 4'hF, 32'h0, 32'hDEAD_BEEF, 1'b1);
      i_xfer(32'hA000_0000, 1'b0, 32'hDEAD_BEEF, 1'b1);
    join
    chk("ea_both", ea, 32'h9000_0000);
    d_xfer(32'h8000_0000, 1'b0, 4'hF, 32'h0, 32'h0, 1'b0);

    bus.d_req_i = 1'b1; bus.d_addr_i = 32'h8000_0400; bus.d_we_i = 1'b1;
    bus.d_be_i = 4'hF; bus.d_wdata_i = 32'h1234_5678;
    bus.i_req_i = 1'b1; bus.i_addr_i = 32'h8000_0400; bus.i_we_i = 1'b0;
    @(negedge clk);
    chk("col_dgnt", 32'(bus.d_gnt_o), 32'd1);
    chk("col_ignt", 32'(bus.i_gnt_o), 32'd0);
    if (bus.d_gnt_o) begin
      e.rd = 32'h0; e.err = 1'b0; e.cyc = cyc;
      dq.push_back(e);
    end
    @(posedge clk);
    #1 bus.d_req_i = 1'b0;
    @(negedge clk);
    chk("col_retry", 32'(bus.i_gnt_o), 32'd1);
    if (bus.i_gnt_o) begin
      e.rd = 32'h1234_5678; e.err = 1'b0; e.cyc = cyc;
      iq.push_back(e);
    end
    @(posedge clk);
    #1 bus.i_req_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("dq_empty", 32'(dq.size()), 32'd0);
    chk("iq_empty", 32'(iq.size()), 32'd0);

    @(posedge clk);
    #1 rst3 = 1'b0;
    repeat (200) @(posedge clk);
    #1 rst3 = 1'b1;
    @(negedge clk);
    chk("s3_rst_busy", 32'(busy3), 32'd1);
    @(posedge clk);
    #1 rst3 = 1'b0;
    cnt = 0;
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk);
      if (!busy3) break;
      cnt++;
    end
    chk("s3_scrub_len", 32'(cnt), 32'd512);
    @(posedge clk);
    #1;
    bus3.i_req_i = 1'b1; bus3.i_addr_i = 32'h8000_1800;
    bus3.d_req_i = 1'b1; bus3.d_addr_i = 32'h8000_17FC;
    @(negedge clk);
    chk("s3_ignt", 32'(bus3.i_gnt_o), 32'd1);
    chk("s3_dgnt", 32'(bus3.d_gnt_o), 32'd1);
    @(posedge clk);
    #1 bus3.i_req_i = 1'b0; bus3.d_req_i = 1'b0;
    @(negedge clk);
    chk("s3_i_rvalid", 32'(bus3.i_rvalid_o), 32'd1);
    chk("s3_i_err", 32'(bus3.i_err_o), 32'd1);
    chk("s3_i_rdata", bus3.i_rdata_o, 32'hDEAD_BEEF);
    chk("s3_d_rvalid", 32'(bus3.d_rvalid_o), 32'd1);
    chk("s3_d_err", 32'(bus3.d_err_o), 32'd0);
    chk("s3_d_rdata", bus3.d_rdata_o, 32'h0);
    chk("s3_ev", 32'(ev3), 32'd1);
    chk("s3_ea", ea3, 32'h8000_1800);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
